key_event_queue: RTL
====================

Name: key_event_queue

Overview:
- Sits between the matrix keypad scanner and the lock control FSM.
- Converts the scanner's level "key pressed" flag and 4-bit key code into clean, single-shot key events in the system clock domain. This replaces the current practice of clocking logic on the flag.
- Provides debounce hold-off and release gating, plus a small FWFT FIFO with a valid/ready handshake, so no keystroke is lost while the FSM is busy.
- Decodes the command keys: F = enter, E = back.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- HOLDOFF, 500000: cycles during which new presses are ignored after an accepted press (10 ms at 50 MHz). Benches use 8.
- CW, 20: hold-off counter width; must satisfy 2^CW > HOLDOFF.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- key_flag  in  1  scanner pressed flag; level, not synchronous to clk
- key_val  in  4  scanner key code; stable while key_flag is high
- flush  in  1  synchronous FIFO clear; also clears overflow
- evt_ready  in  1  consumer accepts the head event
- evt_valid  out  1  FIFO non-empty
- evt_code  out  4  head event code
- evt_enter  out  1  evt_valid and evt_code == 4'hF
- evt_back  out  1  evt_valid and evt_code == 4'hE
- level  out  log2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; set when a press was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n = 0):
  - All outputs 0.
  - Synchroniser flops 0; FIFO pointers and count 0.
  - FSM goes to IDLE; hold-off counter 0.
- Input capture:
  - key_flag passes through a 2-flop synchroniser (s1, s2) and a previous-value register p.
  - rise = s2 & ~p.
  - key_val is registered every cycle into kv.
  - The pushed code is kv at the rise cycle.
- Latency: key_flag rising before clk edge N gives a push at edge N+2, and evt_valid is high from N+2 if the FIFO was empty.
- FSM states:
  - IDLE: on rise, push kv, load counter with HOLDOFF-1, go to HOLD.
  - HOLD: counter decrements each cycle; rise is ignored. At count 0, go to WAIT_REL if s2 = 1, otherwise go to IDLE.
  - WAIT_REL: go to IDLE when s2 = 0; no pushes occur in this state.
- Result: one event per physical press. Chatter within HOLDOFF is suppressed, and a held key never repeats.
- FIFO (first-word fall-through):
  - evt_code always shows the head entry.
  - Pop occurs when evt_valid & evt_ready.
  - evt_ready while empty is ignored.
  - evt_code is don't-care while empty; the bench checks only under evt_valid.
- Boundary conditions:
  - Push while full without a pop in the same cycle: the event is dropped, overflow is set, and the FSM still enters HOLD.
  - Push while full with a pop in the same cycle: both happen, and level stays DEPTH.
  - Push and pop when level is 1: the new entry becomes the head next cycle, and evt_valid stays 1.
  - Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
  - flush: next cycle, level is 0, pointers are 0, and overflow is 0. flush overrides a same-cycle push and pop, but does not disturb the FSM, so a press arriving during a flush is lost and not re-queued.
  - Reset during HOLD or WAIT_REL: everything returns to reset values. A key still held at release of reset produces one event once s2 rises, because p starts at 0.

Test Plan:
1. Single press of key 5 (key_flag high for 20 cycles, HOLDOFF = 8), evt_ready = 0 -> evt_valid rises 2 cycles after key_flag; evt_code = 4'h5; level = 1; only one event is queued.
2. Chatter: key_flag toggles 1,0,1,0,1 at 1-cycle spacing, then stays high 30 cycles -> exactly one event.
3. Long hold: key_flag held high for 100 cycles -> exactly one event. Release, then press again with code 4'hF -> second event with evt_enter = 1.
4. Five presses (codes 1, 2, 3, 4, 7) with evt_ready = 0, DEPTH = 4 -> level = 4, overflow = 1. Popping then yields 1, 2, 3, 4 and evt_valid = 0.
5. Full FIFO with evt_ready = 1 held and a new press of code 9 in the same cycle as a pop -> level stays 4, overflow stays 0, and code 9 emerges last.
6. Queue 2 events, pulse flush -> level = 0, evt_valid = 0, overflow = 0. Assert rst_n = 0 mid-HOLD -> all outputs 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/key_event_queue.sv
// Turns the keypad scanner's asynchronous level flag into single-shot key events.
// Events are queued in a small first-word-fall-through FIFO with a valid/ready handshake.
module key_event_queue #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 500000,
  parameter int CW      = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_flag,
  input  logic [3:0]               key_val,
  input  logic                     flush,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [3:0]               evt_code,
  output logic                     evt_enter,
  output logic                     evt_back,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL  = DEPTH[AW:0];
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

  logic          r_s1, r_s2, r_p;
  logic [3:0]    r_kv;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_rise, w_push_req;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_pop, w_full, w_wr, w_ovf_set;
  logic [3:0]    w_head;

  // Input capture: p starts at 0, so a key held through reset still yields one rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= key_flag;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  always_ff @(posedge clk) begin
    r_kv <= key_val;
  end

  assign w_rise = r_s2 & ~r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push_req)
        r_cnt <= HOLD_LOAD;
      else if (r_state == HOLD && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_push_req  = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt == '0)
          w_state_nxt = r_s2 ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (!r_s2)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIFO: a push into a full queue still succeeds when the head leaves in the same cycle.
  assign w_pop     = evt_valid & evt_ready;
  assign w_full    = (r_count == FULL_LVL);
  assign w_wr      = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_wr)
        r_count <= r_count - 1'b1;
      if (w_ovf_set)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush)
      r_mem[r_wptr] <= r_kv;
  end

  assign w_head    = r_mem[r_rptr];
  assign evt_valid = (r_count != '0);
  assign evt_code  = evt_valid ? w_head : 4'h0;
  assign evt_enter = evt_valid & (w_head == 4'hF);
  assign evt_back  = evt_valid & (w_head == 4'hE);
  assign level     = r_count;
  assign overflow  = r_overflow;

endmodule
